demux_stream: RTL and testbench

Parametrised 1-to-N streaming demultiplexer with a valid/ready handshake on every port and a one-entry registered output stage per channel. Input beats are steered to output channel `S`. The selection can be locked for the duration of a multi-beat packet, so a packet never splits across channels. It sits between a single producer and N independent consumers, for example a frame router in front of per-lane FIFOs. It generalises the combinational 1-to-4 demux to arbitrary width and channel count, adds backpressure, and defines a value on every output at all times.

---
 rtl/demux_stream.sv | 169 ++++++++++++++++
 tb/tb_demux_stream.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// -----------------------------------------------------------------------------
// demux_stream
// Parametrised 1-to-N streaming demultiplexer. Each output channel has a
// one-entry registered stage with a valid/ready handshake. Input beats go to
// channel S. Beats whose select is out of range are accepted, discarded and
// flagged with a one-cycle err pulse.
//
// Optional feature macro: DEMUX_PKT_LOCK_EN
//   defined     : the select is latched at the first beat of a packet and held
//                 until the I_last beat, so a packet never splits across
//                 channels. busy is high while a packet is locked.
//   not defined : every beat is routed by S. busy is tied low.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   I        in   WIDTH   input data
//   I_valid  in   1       input beat present
//   I_last   in   1       final beat of packet
//   I_ready  out  1       beat accepted this cycle (combinational)
//   S        in   SW      channel select, SW = $clog2(N)
//   Y        out  N*WIDTH channel k data on Y[k*WIDTH +: WIDTH]
//   Y_valid  out  N       per-channel beat present
//   Y_last   out  N       per-channel last flag
//   Y_ready  in   N       per-channel consumer ready
//   err      out  1       one-cycle pulse per discarded out-of-range beat
//   busy     out  1       a packet is locked
// -----------------------------------------------------------------------------
module demux_stream #(
   parameter int WIDTH = 8,
   parameter int N     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     I,
   input  logic                 I_valid,
   input  logic                 I_last,
   output logic                 I_ready,
   input  logic [$clog2(N)-1:0] S,
   output logic [N*WIDTH-1:0]   Y,
   output logic [N-1:0]         Y_valid,
   output logic [N-1:0]         Y_last,
   input  logic [N-1:0]         Y_ready,
   output logic                 err,
   output logic                 busy
);

   localparam int SW = $clog2(N);

   logic [SW-1:0]      sel_s;
   logic [N-1:0]       hit_s;
   logic               in_range_s;
   logic               tgt_vld_s;
   logic               tgt_rdy_s;
   logic               ready_s;
   logic               acc_s;

   logic [N*WIDTH-1:0] y_r;
   logic [N-1:0]       y_valid_r;
   logic [N-1:0]       y_last_r;
   logic               err_r;

`ifdef DEMUX_PKT_LOCK_EN
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [0:0]    state_r;
   logic [SW-1:0] lsel_r;

   // Packet lock FSM: latch the select on the first beat of a multi-beat packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         lsel_r  <= {SW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               // Out-of-range selects are latched too, so the whole packet is dropped.
               if (acc_s && !I_last) begin
                  state_r <= ST_LOCK;
                  lsel_r  <= S;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOCK: begin
               if (acc_s && I_last) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_LOCK;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Effective select: the latched channel while locked, else the live select.
   always_comb begin
      if (state_r == ST_LOCK) begin
         sel_s = lsel_r;
      end else begin
         sel_s = S;
      end
   end

   assign busy = (state_r == ST_LOCK);
`else
   assign sel_s = S;
   assign busy  = 1'b0;
`endif

   // One-hot channel decode. An all-zero vector means the select is out of range.
   always_comb begin
      hit_s = {N{1'b0}};
      for (int k = 0; k < N; k++) begin
         hit_s[k] = (sel_s == SW'(k));
      end
   end

   assign in_range_s = |hit_s;
   assign tgt_vld_s  = |(hit_s & y_valid_r);
   assign tgt_rdy_s  = |(hit_s & Y_ready);

   // Input ready: the target stage is empty or pops this cycle.
   // Beats with an out-of-range select are always taken, then dropped.
   always_comb begin
      if (in_range_s) begin
         ready_s = !tgt_vld_s || tgt_rdy_s;
      end else begin
         ready_s = 1'b1;
      end
   end

   assign acc_s = I_valid && ready_s;

   // Per-channel output stages. A load wins over a pop in the same cycle.
   // Data and last are held, not cleared, when a beat pops.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_r       <= {(N*WIDTH){1'b0}};
         y_valid_r <= {N{1'b0}};
         y_last_r  <= {N{1'b0}};
         err_r     <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (acc_s && hit_s[k]) begin
               y_r[k*WIDTH +: WIDTH] <= I;
               y_last_r[k]           <= I_last;
               y_valid_r[k]          <= 1'b1;
            end else if (y_valid_r[k] && Y_ready[k]) begin
               y_valid_r[k] <= 1'b0;
            end else begin
               y_valid_r[k] <= y_valid_r[k];
            end
         end
         err_r <= acc_s && !in_range_s;
      end
   end

   assign I_ready = ready_s;
   assign Y       = y_r;
   assign Y_valid = y_valid_r;
   assign Y_last  = y_last_r;
   assign err     = err_r;

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [7:0]  I;
   logic        I_valid, I_last, I_ready;
   logic [1:0]  S;
   logic [31:0] Y;
   logic [3:0]  Y_valid, Y_last, Y_ready;
   logic        err, busy;

   logic [7:0]  d3_i;
   logic        d3_valid, d3_last, d3_ready;
   logic [1:0]  d3_s;
   logic [23:0] d3_y;
   logic [2:0]  d3_yv, d3_yl, d3_yr;
   logic        d3_err, d3_busy;

   demux_stream #(.WIDTH(8), .N(4)) dut (
      .clk(clk), .rst(rst), .I(I), .I_valid(I_valid), .I_last(I_last),
      .I_ready(I_ready), .S(S), .Y(Y), .Y_valid(Y_valid), .Y_last(Y_last),
      .Y_ready(Y_ready), .err(err), .busy(busy));

   demux_stream #(.WIDTH(8), .N(3)) dut3 (
      .clk(clk), .rst(rst), .I(d3_i), .I_valid(d3_valid), .I_last(d3_last),
      .I_ready(d3_ready), .S(d3_s), .Y(d3_y), .Y_valid(d3_yv), .Y_last(d3_yl),
      .Y_ready(d3_yr), .err(d3_err), .busy(d3_busy));

   int checks = 0;
   int failures = 0;

   // Reference model of the N=4 instance: channel contents plus packet lock.
   bit [7:0] m_data[4];
   bit       m_vld[4];
   bit       m_last[4];
   bit       m_lock;
   int       m_lsel;
   bit       rdy_obs, rdy_exp;

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_data[k] = 8'h00; m_vld[k] = 1'b0; m_last[k] = 1'b0;
      end
      m_lock = 1'b0;
      m_lsel = 0;
   endtask

   function automatic int eff_chan(input int s);
`ifdef DEMUX_PKT_LOCK_EN
      return m_lock ? m_lsel : s;
`else
      return s;
`endif
   endfunction

   // Apply one cycle of stimulus at posedge+1, sample I_ready, advance the
   // model, and return at posedge+1 of the next cycle.
   task automatic drive(input bit v, input bit [7:0] d, input bit l, input int s, input bit [3:0] yr);
      int ch;
      bit acc;
      I_valid = v; I = d; I_last = l; S = s[1:0]; Y_ready = yr;
      #2;
      ch      = eff_chan(s);
      rdy_exp = (ch >= 4) ? 1'b1 : (!m_vld[ch] || yr[ch]);
      rdy_obs = I_ready;
      acc     = v && rdy_exp;
      for (int k = 0; k < 4; k++) begin
         if (acc && k == ch) begin
            m_data[k] = d; m_last[k] = l; m_vld[k] = 1'b1;
         end else if (m_vld[k] && yr[k]) begin
            m_vld[k] = 1'b0;
         end
      end
`ifdef DEMUX_PKT_LOCK_EN
      if (!m_lock) begin
         if (acc && !l) begin m_lock = 1'b1; m_lsel = s; end
      end else if (acc && l) begin
         m_lock = 1'b0;
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; I_valid = 1'b0; I = 8'h00; I_last = 1'b0; S = 2'd0; Y_ready = 4'h0;
      d3_valid = 1'b0; d3_i = 8'h00; d3_last = 1'b0; d3_s = 2'd0; d3_yr = 3'b000;
      @(posedge clk); #1; @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      #1;
      checks++; if (Y !== 32'h0) begin failures++; $display("FAIL reset_y got=%h exp=0", Y); end
      checks++; if (Y_valid !== 4'h0 || Y_last !== 4'h0) begin failures++; $display("FAIL reset_valid_last got=%b/%b exp=0/0", Y_valid, Y_last); end
      checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_err_busy got=%b/%b exp=0/0", err, busy); end
      checks++; if (I_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", I_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_route();
      bit [7:0] e;
      for (int k = 0; k < 4; k++) begin
         e = 8'hA0 + k[7:0];
         drive(1'b1, e, 1'b1, k, 4'hF);
         checks++; if (rdy_obs !== 1'b1) begin failures++; $display("FAIL route_ready ch=%0d got=%b exp=1", k, rdy_obs); end
         checks++; if (Y[k*8 +: 8] !== e || Y_valid[k] !== 1'b1) begin failures++; $display("FAIL route_data ch=%0d got=%h/%b exp=%h/1", k, Y[k*8 +: 8], Y_valid[k], e); end
      end
      drive(1'b0, 8'h00, 1'b0, 0, 4'hF);
   endtask

   task automatic test_backpressure();
      drive(1'b1, 8'hB1, 1'b1, 2, 4'b1011);
      checks++; if (rdy_obs !== 1'b1) begin failures++; $display("FAIL bp_first_ready got=%b exp=1", rdy_obs); end
      checks++; if (Y[23:16] !== 8'hB1 || Y_valid[2] !== 1'b1) begin failures++; $display("FAIL bp_first_held got=%h/%b exp=b1/1", Y[23:16], Y_valid[2]); end
      drive(1'b1, 8'hB2, 1'b1, 2, 4'b1011);
      checks++; if (rdy_obs !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0", rdy_obs); end
      checks++; if (Y[23:16] !== 8'hB1 || Y_valid[2] !== 1'b1) begin failures++; $display("FAIL bp_still_held got=%h/%b exp=b1/1", Y[23:16], Y_valid[2]); end
      drive(1'b1, 8'hB2, 1'b1, 2, 4'hF);
      checks++; if (rdy_obs !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", rdy_obs); end
      checks++; if (Y[23:16] !== 8'hB2 || Y_valid[2] !== 1'b1) begin failures++; $display("FAIL bp_second got=%h/%b exp=b2/1", Y[23:16], Y_valid[2]); end
      drive(1'b0, 8'h00, 1'b0, 0, 4'hF);
   endtask

   task automatic test_packet_lock();
      drive(1'b1, 8'h11, 1'b0, 1, 4'hF);
      checks++; if (Y[15:8] !== 8'h11 || Y_last[1] !== 1'b0) begin failures++; $display("FAIL lock_beat1 got=%h/%b exp=11/0", Y[15:8], Y_last[1]); end
`ifdef DEMUX_PKT_LOCK_EN
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lock_busy1 got=%b exp=1", busy); end
      drive(1'b1, 8'h22, 1'b0, 3, 4'hF);
      checks++; if (Y[15:8] !== 8'h22 || Y_valid !== 4'b0010 || busy !== 1'b1) begin failures++; $display("FAIL lock_beat2 got=%h/%b/%b exp=22/0010/1", Y[15:8], Y_valid, busy); end
      drive(1'b1, 8'h33, 1'b1, 3, 4'hF);
      checks++; if (Y[15:8] !== 8'h33 || Y_last[1] !== 1'b1 || Y_valid !== 4'b0010) begin failures++; $display("FAIL lock_beat3 got=%h/%b/%b exp=33/1/0010", Y[15:8], Y_last[1], Y_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lock_busy_end got=%b exp=0", busy); end
`else
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nolock_busy got=%b exp=0", busy); end
      drive(1'b1, 8'h22, 1'b0, 3, 4'hF);
      checks++; if (Y[31:24] !== 8'h22 || Y_valid !== 4'b1000) begin failures++; $display("FAIL nolock_beat2 got=%h/%b exp=22/1000", Y[31:24], Y_valid); end
      drive(1'b1, 8'h33, 1'b1, 3, 4'hF);
      checks++; if (Y[31:24] !== 8'h33 || Y_last[3] !== 1'b1 || Y_valid !== 4'b1000) begin failures++; $display("FAIL nolock_beat3 got=%h/%b/%b exp=33/1/1000", Y[31:24], Y_last[3], Y_valid); end
`endif
      drive(1'b0, 8'h00, 1'b0, 0, 4'hF);
   endtask

   task automatic test_out_of_range();
      d3_valid = 1'b1; d3_i = 8'h10; d3_s = 2'd0; d3_last = 1'b1; d3_yr = 3'b000;
      @(posedge clk); #1;
      checks++; if (d3_yv !== 3'b001 || d3_y[7:0] !== 8'h10) begin failures++; $display("FAIL oor_preload got=%b/%h exp=001/10", d3_yv, d3_y[7:0]); end
      d3_s = 2'd3; d3_i = 8'h77;
      #2;
      checks++; if (d3_ready !== 1'b1) begin failures++; $display("FAIL oor_ready got=%b exp=1", d3_ready); end
      @(posedge clk); #1;
      d3_valid = 1'b0;
      checks++; if (d3_err !== 1'b1) begin failures++; $display("FAIL oor_err_pulse got=%b exp=1", d3_err); end
      checks++; if (d3_yv !== 3'b001 || d3_y !== 24'h000010) begin failures++; $display("FAIL oor_unchanged got=%b/%h exp=001/000010", d3_yv, d3_y); end
      @(posedge clk); #1;
      checks++; if (d3_err !== 1'b0 || d3_busy !== 1'b0) begin failures++; $display("FAIL oor_err_clear got=%b/%b exp=0/0", d3_err, d3_busy); end
   endtask

   task automatic test_reset_mid_packet();
      drive(1'b1, 8'h40, 1'b0, 0, 4'h0);
      checks++; if (Y_valid[0] !== 1'b1) begin failures++; $display("FAIL rstmid_hold got=%b exp=1", Y_valid[0]); end
      I_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      checks++; if (Y_valid !== 4'h0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_cleared got=%b/%b exp=0000/0", Y_valid, busy); end
      drive(1'b1, 8'h41, 1'b0, 2, 4'h0);
      checks++; if (rdy_obs !== 1'b1 || Y[23:16] !== 8'h41 || Y_valid !== 4'b0100) begin failures++; $display("FAIL rstmid_reroute got=%b/%h/%b exp=1/41/0100", rdy_obs, Y[23:16], Y_valid); end
      drive(1'b1, 8'h42, 1'b1, 2, 4'hF);
      drive(1'b0, 8'h00, 1'b0, 0, 4'hF);
   endtask

   task automatic test_pop_load();
      drive(1'b1, 8'hC0, 1'b1, 0, 4'h0);
      drive(1'b1, 8'h5A, 1'b1, 0, 4'b0001);
      checks++; if (rdy_obs !== 1'b1) begin failures++; $display("FAIL popload_ready got=%b exp=1", rdy_obs); end
      checks++; if (Y_valid[0] !== 1'b1 || Y[7:0] !== 8'h5A) begin failures++; $display("FAIL popload_data got=%b/%h exp=1/5a", Y_valid[0], Y[7:0]); end
      drive(1'b0, 8'h00, 1'b0, 0, 4'hF);
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
               int'($urandom_range(0, 3)), 4'($urandom));
         checks++; if (rdy_obs !== rdy_exp) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", n, rdy_obs, rdy_exp); end
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (Y_valid[k] !== m_vld[k] || Y[k*8 +: 8] !== m_data[k] || Y_last[k] !== m_last[k]) begin
               failures++;
               $display("FAIL rand_chan cyc=%0d ch=%0d got=%b/%h/%b exp=%b/%h/%b", n, k,
                        Y_valid[k], Y[k*8 +: 8], Y_last[k], m_vld[k], m_data[k], m_last[k]);
            end
         end
         checks++; if (busy !== m_lock || err !== 1'b0) begin failures++; $display("FAIL rand_busy_err cyc=%0d got=%b/%b exp=%b/0", n, busy, err, m_lock); end
      end
   endtask

   initial begin
      test_reset();
      test_route();
      test_backpressure();
      test_packet_lock();
      test_out_of_range();
      test_reset_mid_packet();
      test_pop_load();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
